uart_time_set_rx: RTL and testbench
===================================

Name: uart_time_set_rx

Overview:
- Serial command receiver for the clock/calendar. It is the input-side counterpart to the display path.
- Receives ASCII set-time and set-date commands over UART at 8N1, validates them, and emits BCD digit fields plus a one-cycle load strobe.
- Sits beside the clock/calendar core and drives its load inputs. Provides a host-side alternative to the button/switch set path.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 9600, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (10416, integer divide).
- TIMEOUT_MS, 1000, inter-byte timeout; used only when the optional feature is enabled.

Ports:
- clk_100MHz  in  1  system clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  UART receive line; idle high; asynchronous to clk.
- set_time  out  1  one-cycle strobe: time fields valid.
- hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s  out  4 each  BCD time digits.
- am_pm  out  1  0 = AM, 1 = PM.
- set_date  out  1  one-cycle strobe: date fields valid.
- m_10s, m_1s, d_10s, d_1s, c_10s, c_1s, y_10s, y_1s  out  4 each  BCD date digits.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- cmd_err  out  1  one-cycle pulse: malformed or out-of-range command.

Behaviour:
- Reset: all outputs 0; both FSMs idle; counters cleared. Reset mid-byte or mid-command discards all partial data.
- RX front end:
  - 2-FF synchronizer on rx.
  - A falling edge in IDLE starts a byte. At CLKS_PER_BIT/2 the line is re-sampled; if high, treat as a glitch and return to IDLE.
  - Then 8 data bits, LSB first, sampled every CLKS_PER_BIT, then the stop bit.
  - Stop bit high: byte strobe for 1 cycle.
  - Stop bit low: frame_err for 1 cycle, byte discarded, wait for line high before re-arming.
- Parser FSM states: P_IDLE, P_TDIG, P_TAMPM, P_TCR, P_DDIG, P_DCR. A digit index (0..7) tracks position.
- Time command: 'T'(0x54) + 6 digits hhmmss + 'A'(0x41) or 'P'(0x50) + CR(0x0D).
- Date command: 'D'(0x44) + 8 digits MMDDCCYY + CR.
- Digits are 0x30..0x39; the low nibble is stored in a shadow register, never directly in the outputs.
- P_IDLE: ignores CR and LF (0x0A); any other non-T/D byte gives cmd_err.
- Inside a command:
  - 'T' or 'D' gives cmd_err, then the command restarts in P_TDIG or P_DDIG with index 0.
  - Any other unexpected byte gives cmd_err and a return to P_IDLE.
- Range check at CR:
  - hour 01..12, minute 00..59, second 00..59.
  - month 01..12, day 01..31 (month length is not checked here), century and year 00..99.
  - On failure: cmd_err, outputs unchanged.
- Latency: set_time/set_date asserts exactly 1 cycle after the CR byte strobe. The output fields update in that same cycle and hold until the next accepted command of that type.
- The time and date fields are independent; a date command never alters the time outputs.
- frame_err during a command does not abort it by itself; the discarded byte simply never arrives.

Optional Feature:
- Macro RX_TIMEOUT_EN.
- Defined: a counter reloads on every byte strobe. If the parser is outside P_IDLE and TIMEOUT_MS*(CLK_HZ/1000) cycles elapse with no byte, the partial command is discarded, cmd_err pulses once, and the parser returns to P_IDLE.
- Undefined: no counter; a partial command waits indefinitely.

Decomposition:
- Shared package: ASCII constants (CH_T, CH_D, CH_A, CH_P, CH_CR, CH_LF, CH_0), parser state encodings, and the CLKS_PER_BIT derivation.
- One sub-module, uart_rx_byte: synchronizer, bit timer, shift register. Outputs data[7:0], valid, frame_err.
- The parser and range checks stay in uart_time_set_rx.

Test Plan:
- Send "T093005P\r" at 9600 baud -> set_time for 1 cycle after CR; hr=0,9 min=3,0 sec=0,5; am_pm=1; cmd_err stays 0.
- Send "D02292024\r" -> set_date; m=0,2 d=2,9 c=2,0 y=2,4; time outputs unchanged.
- Send "T130000A\r" and "D13010000\r" -> cmd_err at each CR, no strobes, outputs keep previous values.
- Send a byte with the stop bit forced low, then "T120000A\r" -> frame_err pulse; the following command is accepted, with hr=1,2 and am_pm=0.
- Send "T12D01012000\r" -> cmd_err at the 'D', restart; set_date with m=0,1 d=0,1 c=2,0 y=0,0.
- Assert reset after "T1230" is sent, then send "00A\r" -> no set_time, cmd_err on '0' in P_IDLE. With RX_TIMEOUT_EN: "T12" followed by 1 s of idle gives cmd_err, and a later "T010203A\r" is accepted.

Source files
------------

// File: rtl/uart_time_set_rx_pkg.sv
// Shared constants, state encodings and helpers for the UART time/date set receiver.
package uart_time_set_rx_pkg;

  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_D  = 8'h44;
  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_P  = 8'h50;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  typedef enum logic [2:0] {
    P_IDLE, P_TDIG, P_TAMPM, P_TCR, P_DDIG, P_DCR
  } parse_state_t;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_HIGH
  } rx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  localparam int unsigned CLKS_PER_BIT_DEFAULT = clks_per_bit(100000000, 9600);

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

  // Two BCD digits interpreted as a decimal value and compared to [lo, hi].
  function automatic logic bcd_in_range(input logic [3:0] tens, input logic [3:0] ones,
                                        input logic [6:0] lo, input logic [6:0] hi);
    logic [6:0] v;
    v = 7'(tens) * 7'd10 + 7'(ones);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling, glitch reject on start bit.
module uart_rx_byte
  import uart_time_set_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  rx_state_t     state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [2:0]    bit_idx_r, bit_idx_nxt_s;
  logic [7:0]    shift_r, shift_nxt_s, data_nxt_s;
  logic          valid_nxt_s, ferr_nxt_s;
  logic          rx_meta_r, rx_sync_r, rx_prev_r;

  // Synchronizer, edge history, FSM state and registered outputs.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
      state_r   <= R_IDLE;
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      data      <= 8'd0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
      data      <= data_nxt_s;
      valid     <= valid_nxt_s;
      frame_err <= ferr_nxt_s;
    end
  end

  // Bit timing and next-state decode.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r + ONE;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    data_nxt_s    = data;
    valid_nxt_s   = 1'b0;
    ferr_nxt_s    = 1'b0;
    case (state_r)
      R_IDLE: begin
        cnt_nxt_s = '0;
        if (rx_prev_r && !rx_sync_r) state_nxt_s = R_START;
        else                         state_nxt_s = R_IDLE;
      end
      R_START: begin
        if (cnt_r == HALF_M1) begin
          cnt_nxt_s     = '0;
          bit_idx_nxt_s = 3'd0;
          if (!rx_sync_r) state_nxt_s = R_DATA;
          else            state_nxt_s = R_IDLE;
        end else begin
          state_nxt_s = R_START;
        end
      end
      R_DATA: begin
        if (cnt_r == FULL_M1) begin
          cnt_nxt_s   = '0;
          shift_nxt_s = {rx_sync_r, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            state_nxt_s = R_STOP;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_nxt_s = R_DATA;
        end
      end
      R_STOP: begin
        if (cnt_r == FULL_M1) begin
          cnt_nxt_s = '0;
          if (rx_sync_r) begin
            valid_nxt_s = 1'b1;
            data_nxt_s  = shift_r;
            state_nxt_s = R_IDLE;
          end else begin
            ferr_nxt_s  = 1'b1;
            state_nxt_s = R_WAIT_HIGH;
          end
        end else begin
          state_nxt_s = R_STOP;
        end
      end
      R_WAIT_HIGH: begin
        cnt_nxt_s = '0;
        if (rx_sync_r) state_nxt_s = R_IDLE;
        else           state_nxt_s = R_WAIT_HIGH;
      end
      default: begin
        cnt_nxt_s   = '0;
        state_nxt_s = R_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart_time_set_rx.sv
// ASCII set-time / set-date command receiver producing BCD fields and load strobes.
// Optional inter-byte timeout enabled by defining RX_TIMEOUT_EN.
module uart_time_set_rx
  import uart_time_set_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned TIMEOUT_MS = 1000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       rx,
  output logic       set_time,
  output logic [3:0] hr_10s,
  output logic [3:0] hr_1s,
  output logic [3:0] min_10s,
  output logic [3:0] min_1s,
  output logic [3:0] sec_10s,
  output logic [3:0] sec_1s,
  output logic       am_pm,
  output logic       set_date,
  output logic [3:0] m_10s,
  output logic [3:0] m_1s,
  output logic [3:0] d_10s,
  output logic [3:0] d_1s,
  output logic [3:0] c_10s,
  output logic [3:0] c_1s,
  output logic [3:0] y_10s,
  output logic [3:0] y_1s,
  output logic       frame_err,
  output logic       cmd_err
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  logic [7:0]   byte_data_s;
  logic         byte_valid_s, byte_ferr_s;
  parse_state_t p_state_r, p_state_nxt_s;
  logic [2:0]   idx_r, idx_nxt_s;
  logic [3:0]   tsh_r [0:5];
  logic [3:0]   dsh_r [0:7];
  logic         ampm_sh_r;
  logic         tdig_we_s, ddig_we_s, ampm_we_s;
  logic         set_time_nxt_s, set_date_nxt_s, cmd_err_nxt_s;
  logic         time_ok_s, date_ok_s, timeout_s, is_cmd_s;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .rx        (rx),
    .data      (byte_data_s),
    .valid     (byte_valid_s),
    .frame_err (byte_ferr_s)
  );

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYC = TIMEOUT_MS * (CLK_HZ / 1000);
  logic [31:0] to_cnt_r;

  // Idle-time counter, restarted by every received byte.
  always_ff @(posedge clk_100MHz) begin
    if (reset || byte_valid_s || timeout_s || p_state_r == P_IDLE) to_cnt_r <= 32'd0;
    else                                                          to_cnt_r <= to_cnt_r + 32'd1;
  end

  assign timeout_s = (p_state_r != P_IDLE) && !byte_valid_s && (to_cnt_r == 32'(TIMEOUT_CYC - 1));
`else
  localparam int unsigned unused_timeout_cyc = TIMEOUT_MS * (CLK_HZ / 1000);
  assign timeout_s = 1'b0;
`endif

  assign time_ok_s = bcd_in_range(tsh_r[0], tsh_r[1], 7'd1, 7'd12) &&
                     bcd_in_range(tsh_r[2], tsh_r[3], 7'd0, 7'd59) &&
                     bcd_in_range(tsh_r[4], tsh_r[5], 7'd0, 7'd59);
  assign date_ok_s = bcd_in_range(dsh_r[0], dsh_r[1], 7'd1, 7'd12) &&
                     bcd_in_range(dsh_r[2], dsh_r[3], 7'd1, 7'd31) &&
                     bcd_in_range(dsh_r[4], dsh_r[5], 7'd0, 7'd99) &&
                     bcd_in_range(dsh_r[6], dsh_r[7], 7'd0, 7'd99);
  assign is_cmd_s  = (byte_data_s == CH_T) || (byte_data_s == CH_D);

  // Parser next-state, shadow write enables and strobe decode.
  always_comb begin
    p_state_nxt_s  = p_state_r;
    idx_nxt_s      = idx_r;
    cmd_err_nxt_s  = 1'b0;
    set_time_nxt_s = 1'b0;
    set_date_nxt_s = 1'b0;
    tdig_we_s      = 1'b0;
    ddig_we_s      = 1'b0;
    ampm_we_s      = 1'b0;
    if (timeout_s) begin
      p_state_nxt_s = P_IDLE;
      idx_nxt_s     = 3'd0;
      cmd_err_nxt_s = 1'b1;
    end else if (byte_valid_s && p_state_r != P_IDLE && is_cmd_s) begin
      // A new command letter mid-command restarts that command.
      cmd_err_nxt_s = 1'b1;
      idx_nxt_s     = 3'd0;
      if (byte_data_s == CH_T) p_state_nxt_s = P_TDIG;
      else                     p_state_nxt_s = P_DDIG;
    end else if (byte_valid_s) begin
      p_state_nxt_s = P_IDLE;
      idx_nxt_s     = 3'd0;
      case (p_state_r)
        P_IDLE: begin
          if (byte_data_s == CH_T)      p_state_nxt_s = P_TDIG;
          else if (byte_data_s == CH_D) p_state_nxt_s = P_DDIG;
          else if (byte_data_s == CH_CR || byte_data_s == CH_LF) p_state_nxt_s = P_IDLE;
          else                          cmd_err_nxt_s = 1'b1;
        end
        P_TDIG: begin
          if (is_digit(byte_data_s)) begin
            tdig_we_s = 1'b1;
            if (idx_r == 3'd5) begin
              p_state_nxt_s = P_TAMPM;
            end else begin
              p_state_nxt_s = P_TDIG;
              idx_nxt_s     = idx_r + 3'd1;
            end
          end else begin
            cmd_err_nxt_s = 1'b1;
          end
        end
        P_TAMPM: begin
          if (byte_data_s == CH_A || byte_data_s == CH_P) begin
            ampm_we_s     = 1'b1;
            p_state_nxt_s = P_TCR;
          end else begin
            cmd_err_nxt_s = 1'b1;
          end
        end
        P_TCR: begin
          if (byte_data_s == CH_CR && time_ok_s) set_time_nxt_s = 1'b1;
          else                                   cmd_err_nxt_s  = 1'b1;
        end
        P_DDIG: begin
          if (is_digit(byte_data_s)) begin
            ddig_we_s = 1'b1;
            if (idx_r == 3'd7) begin
              p_state_nxt_s = P_DCR;
            end else begin
              p_state_nxt_s = P_DDIG;
              idx_nxt_s     = idx_r + 3'd1;
            end
          end else begin
            cmd_err_nxt_s = 1'b1;
          end
        end
        P_DCR: begin
          if (byte_data_s == CH_CR && date_ok_s) set_date_nxt_s = 1'b1;
          else                                   cmd_err_nxt_s  = 1'b1;
        end
        default: begin
          p_state_nxt_s = P_IDLE;
        end
      endcase
    end else begin
      p_state_nxt_s = p_state_r;
    end
  end

  // Parser state and digit shadow registers.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      p_state_r <= P_IDLE;
      idx_r     <= 3'd0;
      ampm_sh_r <= 1'b0;
      for (int i = 0; i < 6; i++) tsh_r[i] <= 4'd0;
      for (int i = 0; i < 8; i++) dsh_r[i] <= 4'd0;
    end else begin
      p_state_r <= p_state_nxt_s;
      idx_r     <= idx_nxt_s;
      if (tdig_we_s) tsh_r[idx_r] <= byte_data_s[3:0];
      if (ddig_we_s) dsh_r[idx_r] <= byte_data_s[3:0];
      if (ampm_we_s) ampm_sh_r    <= (byte_data_s == CH_P);
    end
  end

  // Output fields load from the shadows only on an accepted command.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      set_time <= 1'b0; set_date <= 1'b0; cmd_err <= 1'b0; frame_err <= 1'b0;
      hr_10s <= 4'd0; hr_1s <= 4'd0; min_10s <= 4'd0; min_1s <= 4'd0;
      sec_10s <= 4'd0; sec_1s <= 4'd0; am_pm <= 1'b0;
      m_10s <= 4'd0; m_1s <= 4'd0; d_10s <= 4'd0; d_1s <= 4'd0;
      c_10s <= 4'd0; c_1s <= 4'd0; y_10s <= 4'd0; y_1s <= 4'd0;
    end else begin
      set_time  <= set_time_nxt_s;
      set_date  <= set_date_nxt_s;
      cmd_err   <= cmd_err_nxt_s;
      frame_err <= byte_ferr_s;
      if (set_time_nxt_s) begin
        hr_10s <= tsh_r[0]; hr_1s <= tsh_r[1]; min_10s <= tsh_r[2]; min_1s <= tsh_r[3];
        sec_10s <= tsh_r[4]; sec_1s <= tsh_r[5]; am_pm <= ampm_sh_r;
      end
      if (set_date_nxt_s) begin
        m_10s <= dsh_r[0]; m_1s <= dsh_r[1]; d_10s <= dsh_r[2]; d_1s <= dsh_r[3];
        c_10s <= dsh_r[4]; c_1s <= dsh_r[5]; y_10s <= dsh_r[6]; y_1s <= dsh_r[7];
      end
    end
  end

endmodule

// File: tb/tb_uart_time_set_rx.sv
// Randomized self-checking bench for uart_time_set_rx against a command-level reference model.
module tb_uart_time_set_rx;

  localparam int unsigned CLK_HZ     = 76800;
  localparam int unsigned BAUD       = 9600;
  localparam int unsigned TIMEOUT_MS = 10;
  localparam int          CPB        = CLK_HZ / BAUD;
  localparam int          TO_CYC     = TIMEOUT_MS * (CLK_HZ / 1000);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic set_time, am_pm, set_date, frame_err, cmd_err;
  logic [3:0] hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s;
  logic [3:0] m_10s, m_1s, d_10s, d_1s, c_10s, c_1s, y_10s, y_1s;

  uart_time_set_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_MS(TIMEOUT_MS)) dut (
    .clk_100MHz(clk), .reset(reset), .rx(rx),
    .set_time(set_time), .hr_10s(hr_10s), .hr_1s(hr_1s), .min_10s(min_10s), .min_1s(min_1s),
    .sec_10s(sec_10s), .sec_1s(sec_1s), .am_pm(am_pm),
    .set_date(set_date), .m_10s(m_10s), .m_1s(m_1s), .d_10s(d_10s), .d_1s(d_1s),
    .c_10s(c_10s), .c_1s(c_1s), .y_10s(y_10s), .y_1s(y_1s),
    .frame_err(frame_err), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  logic [24:0] time_vec, prev_time;
  logic [31:0] date_vec, prev_date;
  assign time_vec = {hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s, am_pm};
  assign date_vec = {m_10s, m_1s, d_10s, d_1s, c_10s, c_1s, y_10s, y_1s};

  int cyc = 0;
  int last_stop_cyc = 0;
  int n_st = 0, n_sd = 0, n_ce = 0, n_fe = 0, n_hold_bad = 0, n_lat_bad = 0;
  int n_checks = 0, n_fail = 0;

  // Reference model state.
  logic [7:0]  cur[$];
  logic [24:0] exp_time = '0;
  logic [31:0] exp_date = '0;
  int exp_st = 0, exp_sd = 0, exp_ce = 0, exp_fe = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counting, strobe latency window and hold-between-strobes monitor.
  always @(negedge clk) begin
    if (set_time) begin
      n_st <= n_st + 1;
      if ((cyc - last_stop_cyc) < CPB / 2 || (cyc - last_stop_cyc) > CPB + 2) n_lat_bad <= n_lat_bad + 1;
    end
    if (set_date) begin
      n_sd <= n_sd + 1;
      if ((cyc - last_stop_cyc) < CPB / 2 || (cyc - last_stop_cyc) > CPB + 2) n_lat_bad <= n_lat_bad + 1;
    end
    if (cmd_err)   n_ce <= n_ce + 1;
    if (frame_err) n_fe <= n_fe + 1;
    if (!reset && !set_time && time_vec !== prev_time) n_hold_bad <= n_hold_bad + 1;
    if (!reset && !set_date && date_vec !== prev_date) n_hold_bad <= n_hold_bad + 1;
    prev_time <= time_vec;
    prev_date <= date_vec;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    wait_clk(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(CPB);
    end
    last_stop_cyc = cyc;
    rx = stop_ok;
    wait_clk(CPB);
    rx = 1'b1;
    if (!stop_ok) wait_clk(CPB);
    wait_clk($urandom_range(0, 3));
  endtask

  function automatic int dval(input logic [7:0] a, input logic [7:0] b);
    return (int'(a) - 48) * 10 + (int'(b) - 48);
  endfunction

  // Command-level model: a command is the byte list since its letter, matched against its template.
  task automatic model_byte(input logic [7:0] b);
    int pos;
    bit fits, is_t;
    if (cur.size() == 0) begin
      if (b == 8'h54 || b == 8'h44) cur.push_back(b);
      else if (b != 8'h0D && b != 8'h0A) exp_ce++;
    end else if (b == 8'h54 || b == 8'h44) begin
      exp_ce++;
      cur.delete();
      cur.push_back(b);
    end else begin
      pos  = cur.size();
      is_t = (cur[0] == 8'h54);
      if (is_t) fits = (pos <= 6) ? (b >= 8'h30 && b <= 8'h39) : (pos == 7) ? (b == 8'h41 || b == 8'h50) : (b == 8'h0D);
      else      fits = (pos <= 8) ? (b >= 8'h30 && b <= 8'h39) : (b == 8'h0D);
      if (!fits) begin
        exp_ce++;
        cur.delete();
      end else if (b == 8'h0D) begin
        if (is_t) begin
          if (dval(cur[1], cur[2]) >= 1 && dval(cur[1], cur[2]) <= 12 &&
              dval(cur[3], cur[4]) <= 59 && dval(cur[5], cur[6]) <= 59) begin
            exp_st++;
            exp_time = {cur[1][3:0], cur[2][3:0], cur[3][3:0], cur[4][3:0], cur[5][3:0], cur[6][3:0], cur[7] == 8'h50};
          end else exp_ce++;
        end else begin
          if (dval(cur[1], cur[2]) >= 1 && dval(cur[1], cur[2]) <= 12 &&
              dval(cur[3], cur[4]) >= 1 && dval(cur[3], cur[4]) <= 31) begin
            exp_sd++;
            exp_date = {cur[1][3:0], cur[2][3:0], cur[3][3:0], cur[4][3:0], cur[5][3:0], cur[6][3:0], cur[7][3:0], cur[8][3:0]};
          end else exp_ce++;
        end
        cur.delete();
      end else begin
        cur.push_back(b);
      end
    end
  endtask

  task automatic send_cmd(input string s, input bit add_cr);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], 1'b1);
      model_byte(s[i]);
    end
    if (add_cr) begin
      send_byte(8'h0D, 1'b1);
      model_byte(8'h0D);
    end
  endtask

  task automatic send_ferr();
    send_byte(8'($urandom_range(0, 255)), 1'b0);
    exp_fe++;
  endtask

  task automatic check_all(input string tag);
    wait_clk(3 * CPB);
    check_val({tag, "_set_time_cnt"}, n_st, exp_st);
    check_val({tag, "_set_date_cnt"}, n_sd, exp_sd);
    check_val({tag, "_cmd_err_cnt"}, n_ce, exp_ce);
    check_val({tag, "_frame_err_cnt"}, n_fe, exp_fe);
    check_val({tag, "_time"}, time_vec, exp_time);
    check_val({tag, "_date"}, date_vec, exp_date);
  endtask

  function automatic logic [7:0] rand_junk();
    logic [7:0] b;
    do b = 8'($urandom_range(8'h20, 8'h7E)); while (b == 8'h54 || b == 8'h44 || (b >= 8'h30 && b <= 8'h39));
    return b;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    int sel, h, m, sec, d;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(2);
    check_val("reset_time", time_vec, 25'd0);
    check_val("reset_date", date_vec, 32'd0);
    check_val("reset_strobes", {set_time, set_date, cmd_err, frame_err}, 4'd0);

    send_cmd("T093005P", 1'b1);
    check_all("t093005p");
    check_val("t093005p_digits", time_vec[24:1], 24'h093005);
    check_val("t093005p_pm", am_pm, 1'b1);

    send_cmd("D02292024", 1'b1);
    check_all("d02292024");
    check_val("d02292024_digits", date_vec, 32'h02292024);
    check_val("d02292024_time_kept", time_vec[24:1], 24'h093005);

    send_cmd("T130000A", 1'b1);
    send_cmd("D13010000", 1'b1);
    check_all("range_rej");

    send_ferr();
    send_cmd("T120000A", 1'b1);
    check_all("ferr_then_t");
    check_val("ferr_then_t_digits", time_vec, {24'h120000, 1'b0});

    send_cmd("T12D01012000", 1'b1);
    check_all("restart");
    check_val("restart_date", date_vec, 32'h01012000);

    send_cmd("T1230", 1'b0);
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    cur.delete();
    exp_time = '0;
    exp_date = '0;
    check_all("mid_reset");
    send_cmd("00A", 1'b1);
    check_all("after_reset");

    send_cmd("T12", 1'b0);
    wait_clk(TO_CYC + 100);
`ifdef RX_TIMEOUT_EN
    cur.delete();
    exp_ce++;
    check_all("timeout");
    send_cmd("T010203A", 1'b1);
    check_all("after_timeout");
`else
    send_cmd("3456A", 1'b1);
    check_all("no_timeout");
`endif

    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 8);
      h   = $urandom_range(1, 12);
      m   = $urandom_range(0, 59);
      sec = $urandom_range(0, 59);
      d   = $urandom_range(1, 31);
      case (sel)
        0: send_cmd($sformatf("T%02d%02d%02d%s", h, m, sec, $urandom_range(0, 1) ? "P" : "A"), 1'b1);
        1: begin
          case ($urandom_range(0, 2))
            0:       h   = $urandom_range(0, 1) ? 0 : $urandom_range(13, 99);
            1:       m   = $urandom_range(60, 99);
            default: sec = $urandom_range(60, 99);
          endcase
          send_cmd($sformatf("T%02d%02d%02dA", h, m, sec), 1'b1);
        end
        2: send_cmd($sformatf("D%02d%02d%02d%02d", h, d, $urandom_range(0, 99), $urandom_range(0, 99)), 1'b1);
        3: begin
          if ($urandom_range(0, 1)) h = $urandom_range(0, 1) ? 0 : $urandom_range(13, 99);
          else                      d = $urandom_range(0, 1) ? 0 : $urandom_range(32, 99);
          send_cmd($sformatf("D%02d%02d%02d%02d", h, d, $urandom_range(0, 99), $urandom_range(0, 99)), 1'b1);
        end
        4: begin
          s = " ";
          s[0] = rand_junk();
          send_cmd(s, 1'b0);
        end
        5: begin
          s = $sformatf("T%06d", $urandom_range(0, 999999));
          s = s.substr(0, $urandom_range(0, 6));
          send_cmd({s, $sformatf("D%02d%02d20%02d", h, d, $urandom_range(0, 99))}, 1'b1);
        end
        6: begin
          send_ferr();
          send_cmd($sformatf("T%02d%02d%02dP", h, m, sec), 1'b1);
        end
        7: begin
          s = "T12 ";
          s[3] = rand_junk();
          send_cmd(s, 1'b1);
        end
        default: begin
          send_cmd($sformatf("T%02d", h), 1'b0);
          send_ferr();
          send_cmd($sformatf("%02d%02dA", m, sec), 1'b1);
        end
      endcase
      check_all($sformatf("rand%0d_sel%0d", it, sel));
    end

    check_val("strobe_latency_window", n_lat_bad, 0);
    check_val("fields_hold_between_strobes", n_hold_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
